instruction_fetch_unit: RTL and testbench

Requester side of the instruction-memory interface: owns the program counter, drives the word address into the synchronous-read instruction memory, and aligns the returned word with its PC. It presents each instruction to decode over a valid/ready handshake, holds the instruction stable under decode stalls, and squashes the in-flight fetch on a taken branch or jump. It sits between the instruction memory and the decode stage.

---
 rtl/instruction_fetch_unit.sv | 115 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: owns the PC, drives a 1-cycle synchronous-read instruction memory and issues to decode over valid/ready.
// Define IFU_MISALIGN_TRAP_EN to trap (halt until reset) on a redirect to a non-word-aligned target.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST_N,
   output logic [31:0] A_IM,
   input  logic [31:0] RD_IM,
   output logic [31:0] INSTR_ID,
   output logic [31:0] PC_ID,
   output logic        VALID_ID,
   input  logic        READY_ID,
   input  logic        REDIRECT,
   input  logic [31:0] TARGET,
   output logic        MISALIGN,
   output logic [31:0] BAD_ADDR
);

   typedef enum logic {RUN, HALT} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_req_q, pc_req_d;
   logic [31:0] pc_rsp_q, pc_rsp_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] tgt;
   logic        bad_tgt;
   logic [29:0] addr;
   logic        valid;

   assign tgt = TARGET & ~32'h3;

`ifdef IFU_MISALIGN_TRAP_EN
   logic        misalign_q, misalign_d;
   logic [31:0] bad_addr_q, bad_addr_d;

   assign bad_tgt  = REDIRECT & (TARGET[1:0] != 2'b00);
   assign MISALIGN = misalign_q;
   assign BAD_ADDR = bad_addr_q;
`else
   assign bad_tgt  = 1'b0;
   assign MISALIGN = 1'b0;
   assign BAD_ADDR = 32'h0000_0000;
`endif

   always_comb begin
      state_d     = state_q;
      pc_req_d    = pc_req_q;
      pc_rsp_d    = pc_rsp_q;
      rsp_valid_d = rsp_valid_q;
`ifdef IFU_MISALIGN_TRAP_EN
      misalign_d  = misalign_q;
      bad_addr_d  = bad_addr_q;
`endif
      valid       = 1'b0;
      addr        = pc_rsp_q[31:2];

      if (state_q == RUN) begin
         if (REDIRECT) begin
            addr = tgt[31:2];
            if (bad_tgt) begin
               state_d     = HALT;
               rsp_valid_d = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
               misalign_d  = 1'b1;
               bad_addr_d  = TARGET;
`endif
            end else begin
               pc_rsp_d    = tgt;
               pc_req_d    = tgt + 32'd4;
               rsp_valid_d = 1'b1;
            end
         end else if (rsp_valid_q && !READY_ID) begin
            // Re-read the held word so RD_IM stays stable while decode stalls.
            valid = 1'b1;
            addr  = pc_rsp_q[31:2];
         end else begin
            valid       = rsp_valid_q;
            addr        = pc_req_q[31:2];
            pc_rsp_d    = pc_req_q;
            pc_req_d    = pc_req_q + 32'd4;
            rsp_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q     <= RUN;
         pc_req_q    <= RESET_PC;
         pc_rsp_q    <= RESET_PC;
         rsp_valid_q <= 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
         misalign_q  <= 1'b0;
         bad_addr_q  <= 32'h0000_0000;
`endif
      end else begin
         state_q     <= state_d;
         pc_req_q    <= pc_req_d;
         pc_rsp_q    <= pc_rsp_d;
         rsp_valid_q <= rsp_valid_d;
`ifdef IFU_MISALIGN_TRAP_EN
         misalign_q  <= misalign_d;
         bad_addr_q  <= bad_addr_d;
`endif
      end
   end

   // Held in reset the registers may not have been cleared yet, so force the reset view.
   assign A_IM     = RST_N ? {2'b00, addr} : {2'b00, RESET_PC[31:2]};
   assign VALID_ID = RST_N & valid;
   assign PC_ID    = pc_rsp_q;
   assign INSTR_ID = RD_IM;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: memory model returns its word address (mem[i]=i), accepted instructions checked against a PC scoreboard.
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ready;
   logic        redirect;
   logic [31:0] target;

   logic [31:0] a0, rd0, instr0, pc0, bad0;
   logic        v0, mis0;
   logic [31:0] a1, rd1, instr1, pc1, bad1;
   logic        v1, mis1;

   int total  = 0;
   int passed = 0;
   logic [31:0] sb_q[$];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      rd0 <= a0;
      rd1 <= a1;
   end

   instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .CLK(clk), .RST_N(rst_n), .A_IM(a0), .RD_IM(rd0), .INSTR_ID(instr0),
      .PC_ID(pc0), .VALID_ID(v0), .READY_ID(ready), .REDIRECT(redirect),
      .TARGET(target), .MISALIGN(mis0), .BAD_ADDR(bad0)
   );

   instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
      .CLK(clk), .RST_N(rst_n), .A_IM(a1), .RD_IM(rd1), .INSTR_ID(instr1),
      .PC_ID(pc1), .VALID_ID(v1), .READY_ID(ready), .REDIRECT(redirect),
      .TARGET(target), .MISALIGN(mis1), .BAD_ADDR(bad1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic push(input logic [31:0] pc);
      sb_q.push_back(pc);
   endtask

   // Retire the current cycle: pop/compare an accepted instruction, then step to just after the next edge.
   task automatic adv();
      logic [31:0] exp_pc;
      if (v0 && ready) begin
         total++;
         assert (sb_q.size() != 0) passed++;
         else $error("FAIL sb_extra observed pc=%h expected=none", pc0);
         if (sb_q.size() != 0) begin
            exp_pc = sb_q.pop_front();
            chk("sb_pc", pc0, exp_pc);
            chk("sb_instr", instr0, exp_pc >> 2);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; ready = 1'b1; redirect = 1'b0; target = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_a_im", a0, 32'h0);
      chk("rst_valid", {31'b0, v0}, 32'h0);
      chk("rst_pc", pc0, 32'h0);
      chk("rst_misalign", {31'b0, mis0}, 32'h0);
      chk("rst_bad_addr", bad0, 32'h0);
      chk("rst_wrap_a_im", a1, 32'h3FFF_FFFE);
      adv();

      // Release: cycle 0 bubble, then one per cycle.
      rst_n = 1'b1;
      push(32'h0); push(32'h4); push(32'h8);
      @(negedge clk);
      chk("c0_a_im", a0, 32'h0);
      chk("c0_valid", {31'b0, v0}, 32'h0);
      adv();
      @(negedge clk);
      chk("c1_valid", {31'b0, v0}, 32'h1);
      chk("c1_a_im", a0, 32'h1);
      chk("wrap_pc_0", pc1, 32'hFFFF_FFF8);
      adv();
      @(negedge clk);
      chk("c2_a_im", a0, 32'h2);
      chk("wrap_pc_1", pc1, 32'hFFFF_FFFC);
      adv();

      // Stall three cycles on PC 8.
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_a_im", a0, 32'h2);
         chk("stall_instr", instr0, 32'h2);
         chk("stall_pc", pc0, 32'h8);
         chk("stall_valid", {31'b0, v0}, 32'h1);
         if (i == 0) chk("wrap_pc_2", pc1, 32'h0);
         adv();
      end
      ready = 1'b1;
      push(32'hC);
      @(negedge clk);
      chk("release_pc", pc0, 32'h8);
      adv();
      push(32'h10);
      @(negedge clk);
      chk("no_gap_valid", {31'b0, v0}, 32'h1);
      chk("no_gap_pc", pc0, 32'hC);
      adv();
      @(negedge clk);
      adv();

      // Redirect to 0, then redirect at PC 4 to 0x40.
      redirect = 1'b1; target = 32'h0;
      @(negedge clk);
      chk("redir0_valid", {31'b0, v0}, 32'h0);
      adv();
      redirect = 1'b0;
      push(32'h0);
      @(negedge clk);
      adv();
      redirect = 1'b1; target = 32'h40;
      @(negedge clk);
      chk("redir40_pc_now", pc0, 32'h4);
      chk("redir40_valid", {31'b0, v0}, 32'h0);
      chk("redir40_a_im", a0, 32'h10);
      adv();
      redirect = 1'b0;
      push(32'h40); push(32'h44);
      @(negedge clk);
      chk("redir40_pc", pc0, 32'h40);
      chk("redir40_instr", instr0, 32'h10);
      adv();
      @(negedge clk);
      adv();

      // Redirect while stalled: stalled 0x48 must never be accepted.
      ready = 1'b0;
      @(negedge clk);
      chk("pre_redir_stall_pc", pc0, 32'h48);
      adv();
      redirect = 1'b1; target = 32'h20;
      @(negedge clk);
      chk("stall_redir_valid", {31'b0, v0}, 32'h0);
      adv();
      redirect = 1'b0; ready = 1'b1;
      push(32'h20);
      @(negedge clk);
      chk("stall_redir_pc", pc0, 32'h20);
      chk("stall_redir_vld", {31'b0, v0}, 32'h1);
      adv();

      // Misaligned redirect target.
      redirect = 1'b1; target = 32'h22;
      @(negedge clk);
      chk("mis_redir_valid", {31'b0, v0}, 32'h0);
      adv();
      redirect = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
      for (int i = 0; i < 3; i++) begin
         redirect = (i == 1);
         target   = 32'h40;
         @(negedge clk);
         chk("trap_misalign", {31'b0, mis0}, 32'h1);
         chk("trap_bad_addr", bad0, 32'h22);
         chk("trap_valid", {31'b0, v0}, 32'h0);
         adv();
      end
      redirect = 1'b0;
`else
      push(32'h20); push(32'h24);
      @(negedge clk);
      chk("mis_pc", pc0, 32'h20);
      chk("mis_instr", instr0, 32'h8);
      chk("mis_flag", {31'b0, mis0}, 32'h0);
      chk("mis_bad_addr", bad0, 32'h0);
      adv();
      @(negedge clk);
      adv();
`endif

      // Reset pulse mid-stall with a redirect pending.
      rst_n = 1'b0; ready = 1'b0; redirect = 1'b1; target = 32'h80;
      @(negedge clk);
      chk("rst2_valid", {31'b0, v0}, 32'h0);
      chk("rst2_a_im", a0, 32'h0);
      adv();
      rst_n = 1'b1; ready = 1'b1; redirect = 1'b0;
      push(32'h0);
      @(negedge clk);
      chk("rst2_c0_valid", {31'b0, v0}, 32'h0);
      chk("rst2_pc_id", pc0, 32'h0);
      adv();
      @(negedge clk);
      chk("rst2_c1_valid", {31'b0, v0}, 32'h1);
      chk("rst2_misalign", {31'b0, mis0}, 32'h0);
      chk("rst2_bad_addr", bad0, 32'h0);
      adv();

      chk("sb_drained", 32'(sb_q.size()), 32'h0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
